// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Synchronizes a raw asynchronous level and debounces it into a
//            clean registered level. Optional glitch counter is enabled by
//            defining INPUT_DEBOUNCER_GLITCH_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                A_Raw,
    output logic                A_Clean,
    output logic                Busy
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    ,
    input  logic                Glitch_Clr,
    output logic [GLITCH_W-1:0] Glitch_Cnt
`endif
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_st_stable_low  = 2'd0;
    localparam logic [1:0] c_st_check_high  = 2'd1;
    localparam logic [1:0] c_st_stable_high = 2'd2;
    localparam logic [1:0] c_st_check_low   = 2'd3;

    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || GLITCH_W < 1) begin : g_bad_param
            $error("input_debouncer: illegal parameter value");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic [1:0]             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_clean;

    // Plain flop chain: nothing may sit between stages of the synchronizer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], A_Raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_st_stable_low;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            case (r_state)
                c_st_stable_low: begin
                    if (w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state <= c_st_stable_high;
                            r_clean <= 1'b1;
                        end else begin
                            r_state <= c_st_check_high;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end
                c_st_check_high: begin
                    if (!w_s) begin
                        r_state <= c_st_stable_low;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_stable_high;
                        r_cnt   <= '0;
                        r_clean <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_stable_high: begin
                    if (!w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state <= c_st_stable_low;
                            r_clean <= 1'b0;
                        end else begin
                            r_state <= c_st_check_low;
                            r_cnt   <= c_cnt_one;
                        end
                    end
                end
                c_st_check_low: begin
                    if (w_s) begin
                        r_state <= c_st_stable_high;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_stable_low;
                        r_cnt   <= '0;
                        r_clean <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_st_stable_low;
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                end
            endcase
        end
    end

    assign A_Clean = r_clean;
    assign Busy    = (r_state == c_st_check_high) || (r_state == c_st_check_low);

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic                w_abort;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    assign w_abort = ((r_state == c_st_check_high) && !w_s) ||
                     ((r_state == c_st_check_low)  &&  w_s);

    // Clear outranks a simultaneous abort; count saturates at all-ones.
    always_ff @(posedge Clk) begin
        if (Rst || Glitch_Clr) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign Glitch_Cnt = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer (three
//            parameterisations).
// Revision : 1.0  initial release
// ============================================================================
module tb_input_debouncer;

    logic r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int r_checks   = 0;
    int r_failures = 0;

    // dut0: defaults; dut1: DEBOUNCE_CYCLES=1; dut2: DEBOUNCE_CYCLES=3
    logic r_rst0 = 1'b1, r_raw0 = 1'b0;
    logic r_rst1 = 1'b1, r_raw1 = 1'b0;
    logic r_rst2 = 1'b1, r_raw2 = 1'b0;
    logic w_clean0, w_busy0, w_clean1, w_busy1, w_clean2, w_busy2;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic r_clr0 = 1'b0, r_clr1 = 1'b0, r_clr2 = 1'b0;
    logic [7:0] w_gcnt0;
    logic [1:0] w_gcnt1, w_gcnt2;
`endif

    input_debouncer u_dut0 (
        .Clk(r_clk), .Rst(r_rst0), .A_Raw(r_raw0), .A_Clean(w_clean0), .Busy(w_busy0)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        , .Glitch_Clr(r_clr0), .Glitch_Cnt(w_gcnt0)
`endif
    );

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .GLITCH_W(2)) u_dut1 (
        .Clk(r_clk), .Rst(r_rst1), .A_Raw(r_raw1), .A_Clean(w_clean1), .Busy(w_busy1)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        , .Glitch_Clr(r_clr1), .Glitch_Cnt(w_gcnt1)
`endif
    );

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .GLITCH_W(2)) u_dut2 (
        .Clk(r_clk), .Rst(r_rst2), .A_Raw(r_raw2), .A_Clean(w_clean2), .Busy(w_busy2)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        , .Glitch_Clr(r_clr2), .Glitch_Cnt(w_gcnt2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        #1;
        // Reset with A_Raw high for two edges.
        r_raw0 = 1'b1;
        tick();
        tick();
        check("rst_clean", 32'(w_clean0), 0);
        check("rst_busy",  32'(w_busy0),  0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("rst_gcnt",  32'(w_gcnt0),  0);
`endif
        // Synchronizer must be empty after reset, so no CHECK entry here.
        r_rst0 = 1'b0;
        r_raw0 = 1'b0;
        tick();
        check("post_rst_busy", 32'(w_busy0), 0);
        tick();
        tick();

        // Clean rise: commit on edge 6, Busy over edges 3..5.
        r_raw0 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("rise_clean_e%0d", e), 32'(w_clean0), (e == 6) ? 1 : 0);
            check($sformatf("rise_busy_e%0d", e),  32'(w_busy0),  (e >= 3 && e <= 5) ? 1 : 0);
        end
        tick();
        tick();
        check("high_hold", 32'(w_clean0), 1);

        // Clean fall.
        r_raw0 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("fall_clean_e%0d", e), 32'(w_clean0), (e == 6) ? 0 : 1);
            check($sformatf("fall_busy_e%0d", e),  32'(w_busy0),  (e >= 3 && e <= 5) ? 1 : 0);
        end
        tick();

        // Two-cycle glitch: abort on edge 5.
        r_raw0 = 1'b1;
        tick();
        tick();
        r_raw0 = 1'b0;
        tick();
        tick();
        check("glitch_busy_e4", 32'(w_busy0), 1);
        tick();
        check("glitch_clean_e5", 32'(w_clean0), 0);
        check("glitch_busy_e5",  32'(w_busy0),  0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("glitch_gcnt_e5", 32'(w_gcnt0), 1);
`endif
        tick();
        tick();

        // Reset while CHECK_HIGH with cnt=2 (after edge 4).
        r_raw0 = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        check("midchk_busy", 32'(w_busy0), 1);
        r_rst0 = 1'b1;
        tick();
        check("midrst_busy",  32'(w_busy0),  0);
        check("midrst_clean", 32'(w_clean0), 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("midrst_gcnt",  32'(w_gcnt0),  0);
`endif
        r_rst0 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("after_rst_clean_e%0d", e), 32'(w_clean0), (e == 6) ? 1 : 0);
        end

        // DEBOUNCE_CYCLES=1: every single-cycle pulse toggles A_Clean up and down.
        tick();
        r_rst1 = 1'b0;
        for (int p = 0; p < 5; p++) begin
            r_raw1 = 1'b1;
            tick();
            r_raw1 = 1'b0;
            tick();
            tick();
            check($sformatf("d1_p%0d_high", p), 32'(w_clean1), 1);
            check($sformatf("d1_p%0d_busy", p), 32'(w_busy1),  0);
            tick();
            check($sformatf("d1_p%0d_low", p),  32'(w_clean1), 0);
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        check("d1_gcnt", 32'(w_gcnt1), 0);
`endif

        // DEBOUNCE_CYCLES=3: two-cycle pulses all abort; 2-bit count saturates at 3.
        r_rst2 = 1'b0;
        tick();
        for (int p = 1; p <= 5; p++) begin
            r_raw2 = 1'b1;
            tick();
            tick();
            r_raw2 = 1'b0;
            for (int e = 3; e <= 6; e++) tick();
            check($sformatf("d3_p%0d_clean", p), 32'(w_clean2), 0);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
            check($sformatf("d3_p%0d_gcnt", p), 32'(w_gcnt2), (p < 3) ? p : 3);
`endif
        end

        // Clear coinciding with an abort edge (edge 5) leaves zero.
        r_raw2 = 1'b1;
        tick();
        tick();
        r_raw2 = 1'b0;
        tick();
        tick();
        check("clr_busy_e4", 32'(w_busy2), 1);
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        r_clr2 = 1'b1;
`endif
        tick();
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        r_clr2 = 1'b0;
        check("clr_gcnt", 32'(w_gcnt2), 0);
`endif
        check("clr_busy_e5",  32'(w_busy2),  0);
        check("clr_clean_e5", 32'(w_clean2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
# input_debouncer

Conditions one raw, asynchronous, possibly bouncing level input (pushbutton, switch, external strobe) into a clean, clock-synchronous level. The block sits directly upstream of the edge detector. `A_Clean` drives the edge detector's data input, so every debounced transition produces exactly one rising or falling edge pulse. It has a multi-flop synchronizer, a four-state debounce FSM with a stability counter, and an optional glitch counter.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth; legal minimum 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples at the new level needed to commit a transition; legal minimum 1.
- `GLITCH_W`, default 8: width of the glitch counter (used only with the macro).
- Counter width is derived as `$clog2(DEBOUNCE_CYCLES+1)`; it is not a parameter.

Ports:
- `Clk`, input, 1: clock. One clock domain, rising edge only.
- `Rst`, input, 1: reset. Synchronous and active-high.
- `A_Raw`, input, 1: asynchronous raw input.
- `A_Clean`, output, 1: debounced level, registered.
- `Busy`, output, 1: high while the FSM is in a CHECK state. It is a decode of the state register only.
- `Glitch_Clr`, input, 1: synchronous clear of `Glitch_Cnt`. Present only with the macro.
- `Glitch_Cnt`, output, `GLITCH_W`: saturating count of aborted transitions. Present only with the macro.

## Operation
Synchronizer:
- `A_Raw` goes through a `SYNC_STAGES`-deep flop chain.
- `s` is the last stage output.
- No logic is placed between the stages.

FSM states are `STABLE_LOW`, `CHECK_HIGH`, `STABLE_HIGH`, `CHECK_LOW`. Counter `cnt` counts consecutive samples of `s` at the candidate level.

- **STABLE_LOW:**
  - `s`=0: stay.
  - `s`=1 and `DEBOUNCE_CYCLES`=1: go to `STABLE_HIGH`; `A_Clean`<=1.
  - `s`=1 otherwise: go to `CHECK_HIGH`; `cnt`<=1.
- **CHECK_HIGH:**
  - `s`=0: abort to `STABLE_LOW`; `cnt`<=0; glitch event.
  - `s`=1 and `cnt`+1==`DEBOUNCE_CYCLES`: go to `STABLE_HIGH`; `A_Clean`<=1; `cnt`<=0.
  - `s`=1 otherwise: `cnt`<=`cnt`+1.
- **STABLE_HIGH / CHECK_LOW:** mirror images of the above, with levels inverted; committing sets `A_Clean`<=0.
- **Other rules:**
  - `A_Clean` changes only on a commit. It never toggles during a CHECK state.
  - `cnt` never exceeds `DEBOUNCE_CYCLES`.
  - Unused state encodings recover to `STABLE_LOW` with `A_Clean`<=0.

## Timing
- **Reset:** with `Rst`=1 sampled at an edge, the following all clear on that edge, regardless of `A_Raw`:
  - all synchronizer stages = 0
  - state = `STABLE_LOW`, `cnt` = 0
  - `A_Clean` = 0, `Busy` = 0, `Glitch_Cnt` = 0
- **Reset mid-operation:** reset dominates every other condition. Any CHECK state or partial count is discarded.
- **Latency:** `A_Raw` changes before edge 1 and then holds. `A_Clean` updates on edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`, which is edge 6 with defaults.
  - `Busy` is high after edges `SYNC_STAGES`+1 through `SYNC_STAGES`+`DEBOUNCE_CYCLES`-1.
  - The downstream edge detector adds one further cycle.
- **Minimum accepted pulse:** `A_Raw` held for at least `DEBOUNCE_CYCLES` cycles. Shorter pulses are rejected.
- **Glitch counter:**
  - Increments by 1 on each abort edge.
  - Saturates at all-ones; never wraps.
  - If `Glitch_Clr` and an abort fall on the same edge, the clear wins and the result is 0.

## Configuration
`INPUT_DEBOUNCER_GLITCH_CNT_EN`:
- **Defined:** the `Glitch_Clr` and `Glitch_Cnt` ports and the counter logic exist, behaving as specified above.
- **Undefined:**
  - The ports are absent and no counter flops are synthesized.
  - Abort behaviour of the FSM is unchanged.

## Test plan
1. **Reset:** `Rst`=1 for 2 edges with `A_Raw`=1 -> after those edges `A_Clean`=0, `Busy`=0, `Glitch_Cnt`=0.
2. **Clean rise (defaults):** `A_Raw` 0->1 before edge 1, held -> `Busy`=1 after edges 3-5; `A_Clean`=1 after edge 6, `Busy`=0.
3. **Clean fall:** from `STABLE_HIGH`, `A_Raw` 1->0 held -> `A_Clean`=0 after edge 6; no change before.
4. **Glitch:** `A_Raw`=1 for 2 cycles then 0 -> `A_Clean` stays 0; `Glitch_Cnt`=1 after edge 5; `Busy`=0 after edge 5.
5. **Reset mid-check:** assert `Rst` while in `CHECK_HIGH` with `cnt`=2, `A_Raw` held 1 -> state resets; `A_Clean` rises on the 6th edge after the first edge that samples `Rst`=0.
6. **Saturation and clear:** `GLITCH_W`=2, `DEBOUNCE_CYCLES`=1.
   - 5 single-cycle `A_Raw` pulses -> `A_Clean` toggles on each, zero glitches.
   - With `DEBOUNCE_CYCLES`=3, 5 two-cycle pulses -> `Glitch_Cnt`=3 (saturated).
   - Then a `Glitch_Clr` pulse coinciding with an abort -> `Glitch_Cnt`=0.
